// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions.
// Opcodes and immediate-format selectors.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator.
// Pure combinational, sign-extended from instr[31].
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opc;

  assign unused_opc = ^instr[6:0];

  // Assemble the 32-bit immediate for the selected format
  always_comb begin
    imm32 = '0;
    unique case (imm_type)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25],
                      instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'h000};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31],
                      instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage.
// Forwarding, load-use stall, one output register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            ex_wreg,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_waddr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            mem_wreg,
  input  logic [4:0]      mem_waddr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            wb_wreg,
  input  logic [4:0]      wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rd,
  output logic            id_wreg,
  output logic            id_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  imm_type_e       imm_type;
  logic            uses_rs1, uses_rs2;
  logic            writes, illegal;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            ex_fwd, hazard, adv, accept;

  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [31:0]     instr_d, instr_q;
  logic [XLEN-1:0] rs1v_d, rs1v_q;
  logic [XLEN-1:0] rs2v_d, rs2v_q;
  logic [XLEN-1:0] imm_d, imm_q;
  logic [4:0]      rd_d, rd_q;
  logic            wreg_d, wreg_q;
  logic            ill_d, ill_q;

  assign opcode    = if_instr[6:0];
  assign rs1       = if_instr[19:15];
  assign rs2       = if_instr[24:20];
  assign rd        = if_instr[11:7];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  // Classify the opcode into format, operand use and legality
  always_comb begin
    imm_type = IMM_NONE;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    writes   = 1'b0;
    illegal  = 1'b0;
    unique case (1'b1)
      opcode == OP_R: begin
        uses_rs2 = 1'b1;
        writes   = 1'b1;
      end
      opcode == OP_IMM,
      opcode == OP_LOAD,
      opcode == OP_JALR: begin
        imm_type = IMM_I;
        writes   = 1'b1;
      end
      opcode == OP_STORE: begin
        imm_type = IMM_S;
        uses_rs2 = 1'b1;
      end
      opcode == OP_BRANCH: begin
        imm_type = IMM_B;
        uses_rs2 = 1'b1;
      end
      opcode == OP_LUI,
      opcode == OP_AUIPC: begin
        imm_type = IMM_U;
        uses_rs1 = 1'b0;
        writes   = 1'b1;
      end
      opcode == OP_JAL: begin
        imm_type = IMM_J;
        uses_rs1 = 1'b0;
        writes   = 1'b1;
      end
      opcode == OP_FENCE,
      opcode == OP_SYSTEM: begin
        imm_type = IMM_I;
      end
      default: illegal = 1'b1;
    endcase
  end

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr   (if_instr),
    .imm_type(imm_type),
    .imm     (imm)
  );

  // A load in EX has no data yet, so it never forwards
  assign ex_fwd = ex_wreg && !ex_is_load;

  // Resolve operands, youngest producer first
  always_comb begin
    rs1_val = rf_rdata1;
    if (rs1 == 5'd0)
      rs1_val = '0;
    else if (ex_fwd && ex_waddr == rs1)
      rs1_val = ex_wdata;
    else if (mem_wreg && mem_waddr == rs1)
      rs1_val = mem_wdata;
    else if (wb_wreg && wb_waddr == rs1)
      rs1_val = wb_wdata;

    rs2_val = rf_rdata2;
    if (rs2 == 5'd0)
      rs2_val = '0;
    else if (ex_fwd && ex_waddr == rs2)
      rs2_val = ex_wdata;
    else if (mem_wreg && mem_waddr == rs2)
      rs2_val = mem_wdata;
    else if (wb_wreg && wb_waddr == rs2)
      rs2_val = wb_wdata;
  end

  // Load-use stall and handshake
  always_comb begin
    hazard = ex_is_load && ex_wreg &&
             (ex_waddr != 5'd0) &&
             ((uses_rs1 && rs1 == ex_waddr) ||
              (uses_rs2 && rs2 == ex_waddr));
    adv      = !valid_q || id_ready;
    if_ready = adv && !hazard && !flush;
    accept   = if_valid && if_ready;
  end

  // Next state of the output register
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    rs1v_d  = rs1v_q;
    rs2v_d  = rs2v_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    wreg_d  = wreg_q;
    ill_d   = ill_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = if_pc;
      instr_d = if_instr;
      rs1v_d  = rs1_val;
      rs2v_d  = rs2_val;
      imm_d   = imm;
      rd_d    = rd;
      wreg_d  = writes && (rd != 5'd0);
      ill_d   = illegal;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= XLEN'(RESET_PC);
      instr_q <= '0;
      rs1v_q  <= '0;
      rs2v_q  <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      wreg_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rs1v_q  <= rs1v_d;
      rs2v_q  <= rs2v_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      wreg_q  <= wreg_d;
      ill_q   <= ill_d;
    end
  end

  assign id_valid   = valid_q;
  assign id_pc      = pc_q;
  assign id_instr   = instr_q;
  assign id_rs1_val = rs1v_q;
  assign id_rs2_val = rs2v_q;
  assign id_imm     = imm_q;
  assign id_rd      = rd_q;
  assign id_wreg    = wreg_q;
  assign id_illegal = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage.
// Directed scenarios plus randomized run against a reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_wreg, ex_is_load;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        wb_wreg;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rd;
  logic        id_wreg, id_illegal;

  int vectors = 0;
  int errs    = 0;

  typedef struct {
    bit          v;
    logic [31:0] pc, instr, r1, r2, imm;
    logic [4:0]  rd;
    bit          wr, ill;
  } mstate_t;

  mstate_t m;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .ex_wreg   (ex_wreg),
    .ex_is_load(ex_is_load),
    .ex_waddr  (ex_waddr),
    .ex_wdata  (ex_wdata),
    .mem_wreg  (mem_wreg),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .wb_wreg   (wb_wreg),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val),
    .id_imm    (id_imm),
    .id_rd     (id_rd),
    .id_wreg   (id_wreg),
    .id_illegal(id_illegal)
  );

  function automatic logic [31:0] mk_r(int rd, int a, int b);
    return {7'd0, 5'(b), 5'(a), 3'd0, 5'(rd), 7'h33};
  endfunction

  // Reference decode from the ISA tables
  function automatic void m_decode(
    input  logic [31:0] ins,
    output logic [31:0] imm,
    output bit wr, output bit ill,
    output bit u1, output bit u2);
    imm = 0; wr = 0; ill = 0; u1 = 1; u2 = 0;
    case (ins[6:0])
      7'h33: begin wr = 1; u2 = 1; end
      7'h13, 7'h03, 7'h67: begin
        wr = 1; imm = 32'($signed(ins[31:20]));
      end
      7'h0F, 7'h73: imm = 32'($signed(ins[31:20]));
      7'h23: begin
        u2 = 1;
        imm = 32'($signed({ins[31:25], ins[11:7]}));
      end
      7'h63: begin
        u2 = 1;
        imm = 32'($signed({ins[31], ins[7], ins[30:25],
                           ins[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin
        wr = 1; u1 = 0; imm = ins[31:12] * 4096;
      end
      7'h6F: begin
        wr = 1; u1 = 0;
        imm = 32'($signed({ins[31], ins[19:12], ins[20],
                           ins[30:21], 1'b0}));
      end
      default: ill = 1;
    endcase
    if (ins[11:7] == 0) wr = 0;
  endfunction

  // Older stages applied first; younger results overwrite them
  function automatic logic [31:0] m_opnd(
    input logic [4:0] rs, input logic [31:0] rf);
    logic [31:0] v;
    v = rf;
    if (rs == 0) return 0;
    if (wb_wreg && wb_waddr == rs) v = wb_wdata;
    if (mem_wreg && mem_waddr == rs) v = mem_wdata;
    if (ex_wreg && !ex_is_load && ex_waddr == rs) v = ex_wdata;
    return v;
  endfunction

  function automatic bit m_if_ready();
    logic [31:0] imm;
    bit wr, ill, u1, u2, hz;
    m_decode(if_instr, imm, wr, ill, u1, u2);
    hz = ex_is_load && ex_wreg && ex_waddr != 0 &&
         ((u1 && if_instr[19:15] == ex_waddr) ||
          (u2 && if_instr[24:20] == ex_waddr));
    return (!m.v || id_ready) && !hz && !flush;
  endfunction

  // Advance one clock, updating the model from current inputs
  task automatic tick();
    mstate_t n;
    bit u1, u2, rdy;
    n = m;
    rdy = m_if_ready();
    if (rst) begin
      n = '{v: 0, pc: 0, instr: 0, r1: 0, r2: 0, imm: 0,
            rd: 0, wr: 0, ill: 0};
    end else if (flush) begin
      n.v = 0;
    end else if (if_valid && rdy) begin
      n.v = 1;
      n.pc = if_pc;
      n.instr = if_instr;
      n.rd = if_instr[11:7];
      n.r1 = m_opnd(if_instr[19:15], rf_rdata1);
      n.r2 = m_opnd(if_instr[24:20], rf_rdata2);
      m_decode(if_instr, n.imm, n.wr, n.ill, u1, u2);
    end else if (!m.v || id_ready) begin
      n.v = 0;
    end
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic clear_fwd();
    ex_wreg = 0; ex_is_load = 0; ex_waddr = 0; ex_wdata = 0;
    mem_wreg = 0; mem_waddr = 0; mem_wdata = 0;
    wb_wreg = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; if_valid = 1; id_ready = 1;
    if_instr = mk_r(3, 1, 2); if_pc = 32'h100;
    rf_rdata1 = 0; rf_rdata2 = 0;
    clear_fwd();
    #1;
    tick(); tick();
    vectors++;
    if (id_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid got %b want 0", id_valid);
    end
    vectors++;
    if (id_pc !== 32'h0) begin
      errs++;
      $display("FAIL reset_pc got %h want 0", id_pc);
    end
    rst = 0;
    #1;
    vectors++;
    if (if_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_if_ready got %b want 1", if_ready);
    end
    vectors++;
    if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin
      errs++;
      $display("FAIL raddr got %0d/%0d want 1/2",
               rf_raddr1, rf_raddr2);
    end
    tick();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
      errs++;
      $display("FAIL first_instr got v=%b pc=%h want v=1 pc=100",
               id_valid, id_pc);
    end
  endtask

  task automatic test_forward();
    logic [31:0] want [4];
    want = '{32'h33, 32'h22, 32'h11, 32'h1};
    if_instr = mk_r(3, 1, 2); rf_rdata1 = 1; rf_rdata2 = 0;
    wb_wreg = 1;  wb_waddr = 1;  wb_wdata = 32'h11;
    mem_wreg = 1; mem_waddr = 1; mem_wdata = 32'h22;
    ex_wreg = 1;  ex_waddr = 1;  ex_wdata = 32'h33;
    for (int i = 0; i < 4; i++) begin
      if_pc = 32'h200 + 32'(4 * i);
      #1;
      tick();
      vectors++;
      if (id_rs1_val !== want[i]) begin
        errs++;
        $display("FAIL fwd_step%0d got %h want %h",
                 i, id_rs1_val, want[i]);
      end
      if (i == 0) ex_wreg = 0;
      if (i == 1) mem_wreg = 0;
      if (i == 2) wb_wreg = 0;
    end
    if_instr = mk_r(3, 0, 0);
    rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'hBEEF;
    ex_wreg = 1; mem_wreg = 1; wb_wreg = 1;
    ex_waddr = 0; mem_waddr = 0; wb_waddr = 0;
    #1;
    tick();
    vectors++;
    if (id_rs1_val !== 0 || id_rs2_val !== 0) begin
      errs++;
      $display("FAIL fwd_x0 got %h/%h want 0/0",
               id_rs1_val, id_rs2_val);
    end
    clear_fwd();
  endtask

  task automatic test_load_use();
    ex_is_load = 1; ex_wreg = 1; ex_waddr = 5;
    if_instr = mk_r(6, 5, 0); if_pc = 32'h300;
    #1;
    vectors++;
    if (if_ready !== 1'b0) begin
      errs++;
      $display("FAIL lu_stall_ready got %b want 0", if_ready);
    end
    tick();
    vectors++;
    if (id_valid !== 1'b0) begin
      errs++;
      $display("FAIL lu_bubble got %b want 0", id_valid);
    end
    ex_is_load = 0; ex_wreg = 0;
    #1;
    tick();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== mk_r(6, 5, 0)) begin
      errs++;
      $display("FAIL lu_accept got v=%b i=%h want v=1 i=%h",
               id_valid, id_instr, mk_r(6, 5, 0));
    end
    ex_is_load = 1; ex_wreg = 1; ex_waddr = 5;
    if_instr = 32'h123452B7; if_pc = 32'h304;
    #1;
    vectors++;
    if (if_ready !== 1'b1) begin
      errs++;
      $display("FAIL lu_lui_ready got %b want 1", if_ready);
    end
    tick();
    vectors++;
    if (id_valid !== 1'b1 || id_imm !== 32'h12345000) begin
      errs++;
      $display("FAIL lu_lui got v=%b imm=%h want v=1 imm=12345000",
               id_valid, id_imm);
    end
    clear_fwd();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    held = id_instr;
    id_ready = 0;
    if_instr = mk_r(7, 1, 1); if_pc = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (if_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_ready%0d got %b want 0", i, if_ready);
      end
      tick();
      vectors++;
      if (id_valid !== 1'b1 || id_instr !== held) begin
        errs++;
        $display("FAIL bp_hold%0d got v=%b i=%h want v=1 i=%h",
                 i, id_valid, id_instr, held);
      end
    end
    id_ready = 1;
    #1;
    tick();
    vectors++;
    if (id_instr !== mk_r(7, 1, 1) || id_pc !== 32'h400) begin
      errs++;
      $display("FAIL bp_release got i=%h pc=%h want i=%h pc=400",
               id_instr, id_pc, mk_r(7, 1, 1));
    end
  endtask

  task automatic test_flush();
    flush = 1; if_instr = mk_r(9, 2, 3); if_pc = 32'h500;
    #1;
    vectors++;
    if (if_ready !== 1'b0) begin
      errs++;
      $display("FAIL flush_ready got %b want 0", if_ready);
    end
    tick();
    vectors++;
    if (id_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_valid got %b want 0", id_valid);
    end
    flush = 0;
    #1;
    tick();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h500) begin
      errs++;
      $display("FAIL flush_after got v=%b pc=%h want v=1 pc=500",
               id_valid, id_pc);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] ins [4];
    logic [31:0] ximm [4];
    bit xill [4];
    bit xwr [4];
    ins  = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h7F};
    ximm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h0};
    xill = '{0, 0, 0, 1};
    xwr  = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      if_instr = ins[i]; if_pc = 32'h600 + 32'(i);
      #1;
      tick();
      vectors++;
      if ((!xill[i] && id_imm !== ximm[i]) ||
          id_illegal !== xill[i] || id_wreg !== xwr[i]) begin
        errs++;
        $display("FAIL imm_%h got imm=%h ill=%b wr=%b want %h/%b/%b",
                 ins[i], id_imm, id_illegal, id_wreg,
                 ximm[i], xill[i], xwr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    logic [31:0] a [9];
    logic [31:0] e [9];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73, 7'h7F};
    for (int n = 0; n < 600; n++) begin
      if_instr = $urandom;
      if_instr[6:0]   = ops[$urandom_range(0, 11)];
      if_instr[11:7]  = 5'($urandom_range(0, 7));
      if_instr[19:15] = 5'($urandom_range(0, 7));
      if_instr[24:20] = 5'($urandom_range(0, 7));
      if_pc = $urandom;
      if_valid = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      ex_wreg = $urandom_range(0, 1);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_waddr = 5'($urandom_range(0, 7)); ex_wdata = $urandom;
      mem_wreg = $urandom_range(0, 1);
      mem_waddr = 5'($urandom_range(0, 7)); mem_wdata = $urandom;
      wb_wreg = $urandom_range(0, 1);
      wb_waddr = 5'($urandom_range(0, 7)); wb_wdata = $urandom;
      #1;
      vectors++;
      if (if_ready !== m_if_ready()) begin
        errs++;
        $display("FAIL rnd%0d if_ready got %b want %b",
                 n, if_ready, m_if_ready());
      end
      tick();
      a = '{32'(id_valid), id_pc, id_instr, id_rs1_val,
            id_rs2_val, id_imm, 32'(id_rd), 32'(id_wreg),
            32'(id_illegal)};
      e = '{32'(m.v), m.pc, m.instr, m.r1, m.r2, m.imm,
            32'(m.rd), 32'(m.wr), 32'(m.ill)};
      for (int k = 0; k < 9; k++) begin
        vectors++;
        if (a[k] !== e[k]) begin
          errs++;
          $display("FAIL rnd%0d field%0d got %h want %h",
                   n, k, a[k], e[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_immediates();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction-decode / operand-fetch stage that sits between fetch and execute, and the sole consumer of the register file read ports.
- Drives the register-file read addresses, then resolves operand values by forwarding from EX, MEM and WB over the register-file data.
- Detects load-use hazards, generates immediates, and holds all results in one output pipeline register with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, value driven on id_pc while in reset (output is don't-care when id_valid=0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill in-flight decode (branch/jump redirect).
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  stage accepts the instruction this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  instruction PC.
- rf_raddr1  out  5  regfile read address 1; combinational, equals if_instr[19:15].
- rf_raddr2  out  5  regfile read address 2; combinational, equals if_instr[24:20].
- rf_rdata1  in  XLEN  regfile read data 1; combinational, x0 reads 0.
- rf_rdata2  in  XLEN  regfile read data 2.
- ex_wreg, ex_is_load  in  1  EX-stage instruction writes rd / is a load.
- ex_waddr  in  5  EX rd.
- ex_wdata  in  XLEN  EX ALU result.
- mem_wreg  in  1  MEM-stage instruction writes rd.
- mem_waddr  in  5  MEM rd.
- mem_wdata  in  XLEN  MEM result.
- wb_wreg  in  1  WB-stage write enable; same signal that drives the regfile write enable.
- wb_waddr  in  5  WB rd.
- wb_wdata  in  XLEN  WB data.
- id_valid  out  1  output register holds a valid decoded instruction.
- id_ready  in  1  execute accepts.
- id_pc  out  XLEN  registered PC.
- id_instr  out  32  registered instruction.
- id_rs1_val, id_rs2_val  out  XLEN  resolved operands.
- id_imm  out  XLEN  sign-extended immediate.
- id_rd  out  5  destination register.
- id_wreg  out  1  instruction writes rd; forced 0 when rd=0.
- id_illegal  out  1  opcode not in RV32I base set.

Behaviour:
- Reset: id_valid=0, id_pc=RESET_PC, every other output register 0. Reset overrides flush and the handshake.
- Decode types by opcode[6:0]:
  - R 0110011; I 0010011 / 0000011 / 1100111; S 0100011; B 1100011; U 0110111 / 0010111; J 1101111.
  - FENCE 0001111 and SYSTEM 1110011 are legal with wreg=0.
  - Any other opcode sets id_illegal=1 and wreg=0.
- Immediates are per the RV32I spec (I, S, B, U, J), sign-extended from bit 31. R-type imm=0.
- uses_rs1 = every type except U and J. uses_rs2 = R, S and B only.
- Forwarding per operand, first match wins:
  - EX when ex_wreg && !ex_is_load && ex_waddr==rs && rs!=0.
  - MEM when mem_wreg && mem_waddr==rs && rs!=0.
  - WB when wb_wreg && wb_waddr==rs && rs!=0. Required because the regfile does not bypass a same-cycle write.
  - Otherwise rf_rdata.
  - rs=0 always yields 0.
- Hazard: ex_is_load && ex_wreg && ex_waddr!=0 && ((uses_rs1 && rs1==ex_waddr) || (uses_rs2 && rs2==ex_waddr)).
- Handshakes:
  - adv = !id_valid || id_ready.
  - if_ready = adv && !hazard && !flush.
  - Load into the output register when if_valid && if_ready. Latency is one cycle: inputs at edge N appear on the outputs after edge N.
  - When adv && (hazard || !if_valid), id_valid is cleared to 0 (bubble) at the next edge.
  - When !adv, all output registers hold and if_ready=0.
- Flush: next edge sets id_valid=0, whatever id_ready is. The instruction offered in the flush cycle is not consumed (if_ready=0). Flush has priority over hazard and load.
- Simultaneous events: hazard with id_ready=0 → hold (no bubble, no accept). The hazard is re-evaluated every cycle against the current EX inputs.

Decomposition:
- riscv_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM) and typedef enum imm_type_e {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}.
- Sub-module imm_gen: combinational, takes instr and imm_type_e, returns the XLEN immediate. Instantiated once.

Test Plan:
- Reset: assert rst 2 cycles with if_valid=1 → id_valid=0, id_pc=0, if_ready=1 after release; first instruction appears one cycle after acceptance.
- Forward priority: ADD x3,x1,x2 with rf_rdata1=1, wb(x1,0x11), mem(x1,0x22), ex non-load(x1,0x33) → id_rs1_val=0x33. Drop EX → 0x22. Drop MEM → 0x11. x0 source with all stages writing x0 → 0.
- Load-use: ex_is_load=1, ex_waddr=5, offer ADD x6,x5,x0 → if_ready=0, one bubble (id_valid=0). Deassert the load → accepted next cycle. Same with LUI x5 offered → no stall.
- Backpressure: id_valid=1, id_ready=0 for 3 cycles → outputs stable and if_ready=0; id_ready=1 → next instruction loaded at the next edge.
- Flush: flush=1 while if_valid=1 and id_valid=1 → id_valid=0 next cycle, if_ready=0 during flush; the instruction is accepted on the following cycle.
- Immediates: 0xFFF00093 (ADDI x1,x0,-1) → imm=0xFFFFFFFF. 0xFE000EE3 (BEQ x0,x0,-4) → imm=0xFFFFFFFC. 0x123450B7 (LUI) → imm=0x12345000. 0x0000007F → id_illegal=1, id_wreg=0.
